// File: rtl/demod_dac_pkg.sv
// Shared definitions for the demod DAC output mux: register map, CTRL field
// positions, the test-tone source code and the saturating gain shift.
package demod_dac_pkg;

   localparam int unsigned SRC_SLOTS      = 16;
   localparam int unsigned DECIM_W        = 16;

   // addr[2] selects the word within a channel's 8-byte slot
   localparam logic        CTRL_WORD      = 1'b0;
   localparam logic        DECIM_WORD     = 1'b1;

   localparam int unsigned CTRL_SRC_LSB   = 0;
   localparam int unsigned CTRL_SRC_W     = 4;
   localparam int unsigned CTRL_SHIFT_LSB = 8;
   localparam int unsigned CTRL_SHIFT_W   = 3;
   localparam int unsigned CTRL_OB_BIT    = 12;
   localparam int unsigned CTRL_EN_BIT    = 31;

   localparam logic [3:0]  TEST_TONE_SRC  = 4'd15;

   // Arithmetic left shift, then clamp to the signed range of a w-bit sample
   function automatic logic signed [63:0] sat_shift(input logic signed [63:0] x,
                                                    input logic [2:0]         sh,
                                                    input int unsigned        w);
      logic signed [63:0] y;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      y  = x <<< sh;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (y > hi) begin
         return hi;
      end else if (y < lo) begin
         return lo;
      end
      return y;
   endfunction

endpackage

// File: rtl/dac_output_channel.sv
// One DAC channel: CTRL/DECIM registers, source select, gain/saturation,
// decimation and the registered DAC sample/strobe.
module dac_output_channel
   import demod_dac_pkg::*;
#(
   parameter int unsigned WIDTH = 18
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [3:0]                 wr_ctrl_i,
   input  logic [3:0]                 wr_decim_i,
   input  logic [15:0]                wdata_lo_i,
   input  logic                       wdata_en_i,
   input  logic [SRC_SLOTS*WIDTH-1:0] src_data_i,
   input  logic [SRC_SLOTS-1:0]       src_sync_i,
   output logic [31:0]                ctrl_o,
   output logic [DECIM_W-1:0]         decim_o,
   output logic [WIDTH-1:0]           dac_data_o,
   output logic                       dac_sync_o
);

   localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

   logic [CTRL_SRC_W-1:0]   src_q, src_d;
   logic [CTRL_SHIFT_W-1:0] shift_q, shift_d;
   logic                    ob_q, ob_d;
   logic                    en_q, en_d;
   logic [DECIM_W-1:0]      decim_q, decim_d;
   logic [DECIM_W-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]        s1_data_q, s1_data_d;
   logic                    s1_sync_q, s1_sync_d;
   logic [WIDTH-1:0]        s2_data_q, s2_data_d;
   logic                    s2_pass_q, s2_pass_d;
   logic [WIDTH-1:0]        dac_data_q, dac_data_d;
   logic                    dac_sync_q, dac_sync_d;
   logic                    reg_wr_c;
   logic [WIDTH-1:0]        shaped_c;

   always_comb begin
      src_d      = src_q;
      shift_d    = shift_q;
      ob_d       = ob_q;
      en_d       = en_q;
      decim_d    = decim_q;
      cnt_d      = cnt_q;
      s2_pass_d  = 1'b0;
      dac_data_d = dac_data_q;
      dac_sync_d = 1'b0;
      reg_wr_c   = |{wr_ctrl_i, wr_decim_i};

      if (wr_ctrl_i[0]) src_d = wdata_lo_i[CTRL_SRC_LSB +: CTRL_SRC_W];
      if (wr_ctrl_i[1]) begin
         shift_d = wdata_lo_i[CTRL_SHIFT_LSB +: CTRL_SHIFT_W];
         ob_d    = wdata_lo_i[CTRL_OB_BIT];
      end
      if (wr_ctrl_i[3])  en_d          = wdata_en_i;
      if (wr_decim_i[0]) decim_d[7:0]  = wdata_lo_i[7:0];
      if (wr_decim_i[1]) decim_d[15:8] = wdata_lo_i[15:8];

      s1_data_d = src_data_i[32'(src_q)*WIDTH +: WIDTH];
      s1_sync_d = src_sync_i[src_q];

      shaped_c  = WIDTH'(sat_shift(64'($signed(s1_data_q)), shift_q, WIDTH));
      s2_data_d = shaped_c ^ (ob_q ? MSB : '0);

      // A register write restarts decimation and swallows a coincident sync
      if (!en_q || reg_wr_c) begin
         cnt_d = '0;
      end else if (s1_sync_q) begin
         if (cnt_q == decim_q) begin
            s2_pass_d = 1'b1;
            cnt_d     = '0;
         end else begin
            cnt_d = cnt_q + DECIM_W'(1);
         end
      end

      if (!en_q) begin
         dac_data_d = ob_q ? MSB : '0;
      end else begin
         dac_sync_d = s2_pass_q;
         if (s2_pass_q) dac_data_d = s2_data_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_q      <= '0;
         shift_q    <= '0;
         ob_q       <= 1'b0;
         en_q       <= 1'b0;
         decim_q    <= '0;
         cnt_q      <= '0;
         s1_data_q  <= '0;
         s1_sync_q  <= 1'b0;
         s2_data_q  <= '0;
         s2_pass_q  <= 1'b0;
         dac_data_q <= '0;
         dac_sync_q <= 1'b0;
      end else begin
         src_q      <= src_d;
         shift_q    <= shift_d;
         ob_q       <= ob_d;
         en_q       <= en_d;
         decim_q    <= decim_d;
         cnt_q      <= cnt_d;
         s1_data_q  <= s1_data_d;
         s1_sync_q  <= s1_sync_d;
         s2_data_q  <= s2_data_d;
         s2_pass_q  <= s2_pass_d;
         dac_data_q <= dac_data_d;
         dac_sync_q <= dac_sync_d;
      end
   end

   always_comb begin
      ctrl_o = '0;
      ctrl_o[CTRL_SRC_LSB +: CTRL_SRC_W]     = src_q;
      ctrl_o[CTRL_SHIFT_LSB +: CTRL_SHIFT_W] = shift_q;
      ctrl_o[CTRL_OB_BIT]                    = ob_q;
      ctrl_o[CTRL_EN_BIT]                    = en_q;
   end

   assign decim_o    = decim_q;
   assign dac_data_o = dac_data_q;
   assign dac_sync_o = dac_sync_q;

endmodule

// File: rtl/demod_dac_output_mux.sv
// Demod DAC output mux: register decode, read-back OR-tree and NUM_DAC channels.
// Build option DAC_TEST_TONE_EN adds a sawtooth test tone selectable as source 15.
module demod_dac_output_mux
   import demod_dac_pkg::*;
#(
   parameter int unsigned NUM_DAC   = 3,
   parameter int unsigned NUM_SRC   = 8,
   parameter int unsigned WIDTH     = 18,
   parameter logic [11:0] ADDR_BASE = 12'h100
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       rd,
   input  logic                       wr0,
   input  logic                       wr1,
   input  logic                       wr2,
   input  logic                       wr3,
   input  logic [11:0]                addr,
   input  logic [31:0]                din,
   output logic [31:0]                dout,
   input  logic [NUM_SRC*WIDTH-1:0]   srcData,
   input  logic [NUM_SRC-1:0]         srcSync,
   output logic [NUM_DAC*WIDTH-1:0]   dacData,
   output logic [NUM_DAC-1:0]         dacSync
);

   logic                       hit_c;
   logic [1:0]                 ch_c;
   logic                       reg_c;
   logic [3:0]                 wr_be_c;
   logic [SRC_SLOTS*WIDTH-1:0] slot_data;
   logic [SRC_SLOTS-1:0]       slot_sync;
   logic [31:0]                ctrl_rd [NUM_DAC];
   logic [DECIM_W-1:0]         decim_rd [NUM_DAC];
   logic                       unused_bits_c;

   assign hit_c         = (addr[11:5] == ADDR_BASE[11:5]);
   assign ch_c          = addr[4:3];
   assign reg_c         = addr[2];
   assign wr_be_c       = {wr3, wr2, wr1, wr0};
   assign unused_bits_c = ^{din[30:16], addr[1:0]};

`ifdef DAC_TEST_TONE_EN
   logic [WIDTH-1:0] tone_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) tone_q <= '0;
      else       tone_q <= tone_q + WIDTH'(1);
   end
`endif

   // Expand sources into a fixed 16-slot table; unused slots never sync
   for (genvar k = 0; k < SRC_SLOTS; k++) begin : g_slot
      if (k < NUM_SRC) begin : g_src
         assign slot_data[k*WIDTH +: WIDTH] = srcData[k*WIDTH +: WIDTH];
         assign slot_sync[k]                = srcSync[k];
      end
`ifdef DAC_TEST_TONE_EN
      else if (k == 32'(TEST_TONE_SRC)) begin : g_tone
         assign slot_data[k*WIDTH +: WIDTH] = tone_q;
         assign slot_sync[k]                = 1'b1;
      end
`endif
      else begin : g_none
         assign slot_data[k*WIDTH +: WIDTH] = '0;
         assign slot_sync[k]                = 1'b0;
      end
   end

   for (genvar c = 0; c < NUM_DAC; c++) begin : g_ch
      logic sel_c;
      assign sel_c = hit_c && (ch_c == 2'(c));

      dac_output_channel #(.WIDTH(WIDTH)) u_ch (
         .clk        (clk),
         .reset      (reset),
         .wr_ctrl_i  ((sel_c && reg_c == CTRL_WORD)  ? wr_be_c : 4'b0),
         .wr_decim_i ((sel_c && reg_c == DECIM_WORD) ? wr_be_c : 4'b0),
         .wdata_lo_i (din[15:0]),
         .wdata_en_i (din[CTRL_EN_BIT]),
         .src_data_i (slot_data),
         .src_sync_i (slot_sync),
         .ctrl_o     (ctrl_rd[c]),
         .decim_o    (decim_rd[c]),
         .dac_data_o (dacData[c*WIDTH +: WIDTH]),
         .dac_sync_o (dacSync[c])
      );
   end

   always_comb begin
      dout = '0;
      if (rd && hit_c) begin
         for (int unsigned c = 0; c < NUM_DAC; c++) begin
            if (ch_c == 2'(c)) dout |= (reg_c == DECIM_WORD) ? 32'(decim_rd[c]) : ctrl_rd[c];
         end
      end
   end

endmodule

// File: tb/tb_demod_dac_output_mux.sv
// Self-checking bench for demod_dac_output_mux against a behavioural model.
module tb_demod_dac_output_mux;

   localparam int unsigned NUM_DAC = 3;
   localparam int unsigned NUM_SRC = 8;
   localparam int unsigned W       = 18;
   localparam logic [11:0] BASE    = 12'h100;

   logic                   clk;
   logic                   reset;
   logic                   rd, wr0, wr1, wr2, wr3;
   logic [11:0]            addr;
   logic [31:0]            din;
   logic [31:0]            dout;
   logic [NUM_SRC*W-1:0]   srcData;
   logic [NUM_SRC-1:0]     srcSync;
   logic [NUM_DAC*W-1:0]   dacData;
   logic [NUM_DAC-1:0]     dacSync;

   int checks   = 0;
   int failures = 0;

   // Model: register words as the bus sees them, plus the sample/pass history
   logic [31:0]  m_ctrl  [NUM_DAC];
   logic [31:0]  m_decim [NUM_DAC];
   int unsigned  m_cnt   [NUM_DAC];
   logic [W-1:0] p1_val  [NUM_DAC];
   bit           p1_sync [NUM_DAC];
   logic [W-1:0] p2_val  [NUM_DAC];
   bit           p2_pass [NUM_DAC];
   logic [W-1:0] exp_data[NUM_DAC];
   bit           exp_sync[NUM_DAC];
   logic [W-1:0] tone_m;

   demod_dac_output_mux #(
      .NUM_DAC(NUM_DAC), .NUM_SRC(NUM_SRC), .WIDTH(W), .ADDR_BASE(BASE)
   ) dut (
      .clk(clk), .reset(reset), .rd(rd),
      .wr0(wr0), .wr1(wr1), .wr2(wr2), .wr3(wr3),
      .addr(addr), .din(din), .dout(dout),
      .srcData(srcData), .srcSync(srcSync),
      .dacData(dacData), .dacSync(dacSync)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic logic [W-1:0] shape(input logic [W-1:0] x, input int sh, input bit ob);
      longint v;
      longint lim;
      logic [W-1:0] r;
      v = longint'($signed(x));
      for (int i = 0; i < sh; i++) v = v * 2;
      lim = longint'(1) << (W - 1);
      if (v > lim - 1) v = lim - 1;
      else if (v < -lim) v = -lim;
      r = W'(v);
      if (ob) r[W-1] = ~r[W-1];
      return r;
   endfunction

   function automatic logic [31:0] model_read(input logic [11:0] a);
      int off;
      off = int'(a) - int'(BASE);
      if (off < 0 || off >= 32 || off / 8 >= int'(NUM_DAC)) return 32'h0;
      return ((off / 4) % 2 == 1) ? m_decim[off/8] : m_ctrl[off/8];
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NUM_DAC; c++) begin
         m_ctrl[c] = '0; m_decim[c] = '0; m_cnt[c] = 0;
         p1_val[c] = '0; p1_sync[c] = 0; p2_val[c] = '0; p2_pass[c] = 0;
         exp_data[c] = '0; exp_sync[c] = 0;
      end
      tone_m = '0;
   endtask

   // Advance the model by one clock using the inputs the bench is driving
   task automatic model_edge();
      int off;
      logic [3:0] lanes;
      lanes = {wr3, wr2, wr1, wr0};
      off   = int'(addr) - int'(BASE);
      for (int c = 0; c < NUM_DAC; c++) begin
         bit en, ob, wrote, pass;
         int sh, s;
         logic [31:0] w;
         en    = m_ctrl[c][31];
         ob    = m_ctrl[c][12];
         sh    = int'(m_ctrl[c][10:8]);
         s     = int'(m_ctrl[c][3:0]);
         wrote = (off >= 0) && (off < 32) && (off / 8 == c) && (lanes != 4'b0);
         if (!en) begin
            exp_data[c] = ob ? {1'b1, {(W-1){1'b0}}} : '0;
            exp_sync[c] = 0;
         end else begin
            exp_sync[c] = p2_pass[c];
            if (p2_pass[c]) exp_data[c] = p2_val[c];
         end
         pass = 0;
         if (!en || wrote) m_cnt[c] = 0;
         else if (p1_sync[c]) begin
            if (m_cnt[c] == int'(m_decim[c][15:0])) begin
               pass = 1;
               m_cnt[c] = 0;
            end else m_cnt[c] = m_cnt[c] + 1;
         end
         p2_val[c]  = shape(p1_val[c], sh, ob);
         p2_pass[c] = pass;
         if (s < int'(NUM_SRC)) begin
            p1_val[c]  = srcData[s*W +: W];
            p1_sync[c] = srcSync[s];
         end else begin
            p1_val[c]  = '0;
            p1_sync[c] = 0;
`ifdef DAC_TEST_TONE_EN
            if (s == 15) begin
               p1_val[c]  = tone_m;
               p1_sync[c] = 1;
            end
`endif
         end
         if (wrote) begin
            w = ((off / 4) % 2 == 1) ? m_decim[c] : m_ctrl[c];
            for (int b = 0; b < 4; b++) if (lanes[b]) w[b*8 +: 8] = din[b*8 +: 8];
            if ((off / 4) % 2 == 1) m_decim[c] = w & 32'h0000_FFFF;
            else                    m_ctrl[c]  = w & 32'h8000_170F;
         end
      end
      tone_m = tone_m + W'(1);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      for (int c = 0; c < NUM_DAC; c++) begin
         check($sformatf("dacData[%0d]", c), 32'(dacData[c*W +: W]), 32'(exp_data[c]));
         check($sformatf("dacSync[%0d]", c), 32'(dacSync[c]), 32'(exp_sync[c]));
      end
      check("dout_idle", dout, 32'h0);
      @(negedge clk);
      {wr3, wr2, wr1, wr0} = 4'b0;
   endtask

   task automatic reg_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] lanes);
      addr = a;
      din  = d;
      {wr3, wr2, wr1, wr0} = lanes;
      cycle();
      addr = 12'h0;
      din  = 32'h0;
   endtask

   task automatic read_check(input logic [11:0] a);
      rd   = 1'b1;
      addr = a;
      #1;
      check($sformatf("read@%0h", a), dout, model_read(a));
      rd   = 1'b0;
      addr = 12'h0;
   endtask

   task automatic read_lit(input string name, input logic [11:0] a, input logic [31:0] req);
      rd   = 1'b1;
      addr = a;
      #1;
      check(name, dout, req);
      rd   = 1'b0;
      addr = 12'h0;
   endtask

   task automatic set_src(input int k, input logic [W-1:0] v);
      srcData[k*W +: W] = v;
   endtask

   initial begin
      int gap;
      int pulses;
      logic [11:0] a;
      logic [31:0] d;

      reset = 1'b1; rd = 1'b0; {wr3, wr2, wr1, wr0} = 4'b0;
      addr = 12'h0; din = 32'h0; srcData = '0; srcSync = '0;
      model_reset();
      #12;
      check("reset_data", 32'(dacData), 32'h0);
      check("reset_sync", 32'(dacSync), 32'h0);
      read_lit("reset_ctrl0", BASE, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Straight-through channel 0
      reg_write(BASE, 32'h8000_0002, 4'hF);
      read_check(BASE);
      set_src(2, 18'h00123);
      srcSync = 8'b0000_0100;
      cycle();
      srcSync = '0;
      cycle();
      cycle();
      check("ch0_pulse", 32'(dacSync[0]), 32'h1);
      check("ch0_data", 32'(dacData[0*W +: W]), 32'h00123);
      cycle();
      check("ch0_pulse_end", 32'(dacSync[0]), 32'h0);
      check("ch0_hold", 32'(dacData[0*W +: W]), 32'h00123);

      // Channel 1 gain with saturation both ways
      reg_write(BASE + 12'h008, 32'h8000_0301, 4'hF);
      set_src(1, 18'h08000);
      srcSync = 8'b0000_0010;
      cycle();
      srcSync = '0;
      cycle();
      cycle();
      check("ch1_sat_pos", 32'(dacData[1*W +: W]), 32'h1FFFF);
      set_src(1, 18'h38000);
      srcSync = 8'b0000_0010;
      cycle();
      srcSync = '0;
      cycle();
      cycle();
      check("ch1_sat_neg", 32'(dacData[1*W +: W]), 32'h20000);

      // Channel 2 decimation by 4 and write-restart
      reg_write(BASE + 12'h010, 32'h8000_0004, 4'hF);
      reg_write(BASE + 12'h014, 32'h0000_0003, 4'hF);
      read_check(BASE + 12'h014);
      srcSync = 8'b0001_0000;
      for (int i = 0; i < 4; i++) begin set_src(4, W'($urandom)); cycle(); end
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         set_src(4, W'($urandom));
         cycle();
         if (dacSync[2]) pulses++;
      end
      check("ch2_decim_pulses", 32'(pulses), 32'd4);
      reg_write(BASE + 12'h014, 32'h0000_0003, 4'b0011);
      gap = 0;
      for (int i = 1; i <= 20; i++) begin
         cycle();
         if (dacSync[2]) begin gap = i; break; end
      end
      check("ch2_restart_gap", 32'(gap), 32'd5);
      srcSync = '0;

      // Out-of-range source and single-lane write
      reg_write(BASE, 32'h0, 4'hF);
      reg_write(BASE, 32'h8000_0009, 4'hF);
      srcSync = '1;
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < NUM_SRC; k++) set_src(k, W'($urandom));
         cycle();
      end
      check("ch0_oor_sync", 32'(dacSync[0]), 32'h0);
      check("ch0_oor_data", 32'(dacData[0*W +: W]), 32'h0);
      reg_write(BASE, 32'h0000_0005, 4'b0001);
      read_lit("ch0_byte0_only", BASE, 32'h8000_0005);
      srcSync = '0;

      // Source 15: test tone when built in, otherwise silent
      reg_write(BASE + 12'h008, 32'h0, 4'hF);
      reg_write(BASE + 12'h008, 32'h8000_000F, 4'hF);
      for (int i = 0; i < 8; i++) cycle();
`ifdef DAC_TEST_TONE_EN
      check("tone_sync", 32'(dacSync[1]), 32'h1);
`else
      check("tone_off_sync", 32'(dacSync[1]), 32'h0);
      check("tone_off_data", 32'(dacData[1*W +: W]), 32'h0);
`endif

      // Randomised traffic
      for (int n = 0; n < 2500; n++) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            set_src(k, W'($urandom));
            srcSync[k] = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 5) == 0) read_check(BASE + 12'($urandom_range(0, 7) * 4));
         if ($urandom_range(0, 5) == 0) begin
            a = ($urandom_range(0, 9) == 0) ? 12'($urandom) : BASE + 12'($urandom_range(0, 7) * 4);
            d = $urandom;
            if (a[2]) d[15:0] = 16'($urandom_range(0, 3));
            else d[31] = ($urandom_range(0, 4) != 0);
            addr = a;
            din  = d;
            {wr3, wr2, wr1, wr0} = 4'($urandom_range(1, 15));
            cycle();
            addr = 12'h0;
            din  = 32'h0;
         end else begin
            cycle();
         end
      end

      // Asynchronous reset in the middle of a running stream
      srcSync = '0;
      reg_write(BASE + 12'h004, 32'h0, 4'hF);
      reg_write(BASE, 32'h8000_0000, 4'hF);
      set_src(0, 18'h00555);
      srcSync = 8'b0000_0001;
      for (int i = 0; i < 6; i++) cycle();
      check("pre_reset_data", 32'(dacData[0*W +: W]), 32'h00555);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_data", 32'(dacData), 32'h0);
      check("async_reset_sync", 32'(dacSync), 32'h0);
      read_lit("async_reset_ctrl0", BASE, 32'h0);
      @(posedge clk);
      #1;
      check("held_reset_data", 32'(dacData), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      reg_write(BASE, 32'h8000_1000, 4'hF);
      for (int i = 0; i < 20; i++) begin
         set_src(0, W'($urandom));
         srcSync[0] = 1'($urandom_range(0, 1));
         cycle();
      end
      read_check(BASE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/demod_dac_output_mux.md
Name: demod_dac_output_mux

Overview:
- Parametrised successor to the fixed three-DAC demod output path.
- Routes any of NUM_SRC internal demod signals (I/Q baseband, loop errors, AGC, etc.) to any of NUM_DAC DAC channels.
- Each channel has a register-programmed source select, gain shift with saturation, output format and sync decimation.
- Sits at the bottom of the demod top, between the demod datapath and the DAC drivers, on the standard 32-bit microprocessor register bus.

Parameters:
- NUM_DAC, 3, number of DAC output channels (1..4).
- NUM_SRC, 8, number of selectable sources (1..15).
- WIDTH, 18, signed sample width of sources and DAC outputs.
- ADDR_BASE, 12'h100, base byte address of the register block; 32-byte aligned.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- rd  in  1  register read strobe.
- wr0, wr1, wr2, wr3  in  1 each  byte-lane write strobes for din[7:0], [15:8], [23:16], [31:24].
- addr  in  12  byte address.
- din  in  32  write data.
- dout  out  32  read data; 0 when not selected.
- srcData  in  NUM_SRC*WIDTH  packed signed sources; source k is at [k*WIDTH +: WIDTH].
- srcSync  in  NUM_SRC  per-source sample-valid pulse.
- dacData  out  NUM_DAC*WIDTH  packed DAC samples.
- dacSync  out  NUM_DAC  per-channel sample strobe.

Behaviour:
- Register decode:
  - Hit when addr[11:5] == ADDR_BASE[11:5].
  - Channel = addr[4:3]; reg = addr[2] (0 = CTRL, 1 = DECIM).
  - Channels >= NUM_DAC are not writable and read 0.
- CTRL register fields (reset 0):
  - [3:0] src select.
  - [10:8] shift (0..7).
  - [12] offset-binary (invert MSB of output).
  - [31] enable.
  - Unused bits read 0.
- DECIM register: [15:0] D (reset 0).
- Writes are byte-lane gated and take effect on the next clk edge. dout is combinational, equal to register contents when rd && hit, else 0.
- Reset: all registers 0, dacData 0, dacSync 0, decimation counters 0; effective immediately and asynchronously, including mid-operation.
- Stage 1 (per channel):
  - Register the selected source sample and its sync.
  - src >= NUM_SRC selects data 0 with sync never asserted, except code 15 when DAC_TEST_TONE_EN is defined.
- Stage 2 (per channel):
  - Arithmetic left shift by `shift` at full WIDTH+7 precision.
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1], then apply the offset-binary inversion.
- Decimation counter:
  - Counts stage-1 syncs.
  - On a stage-1 sync with count == D: pass the sample (load dacData, pulse dacSync) and clear the count. Otherwise increment the count.
  - D = 0 passes every sample.
- Latency: srcSync at edge n produces dacSync high for exactly one cycle after edge n+2, with dacData updated on the same edge.
- dacData holds its value between passed syncs.
- A write to CTRL or DECIM of a channel clears that channel's decimation counter. If the write coincides with a sync, the clear wins and that sync is not passed.
- Enable = 0: dacData forced to 0 (0x20000 if offset-binary), dacSync held 0, counter held 0.
- Changing src mid-stream: the stage-1 pipeline value already in flight completes; there is no glitch beyond one sample.

Optional Feature:
- Macro DAC_TEST_TONE_EN.
- Defined:
  - Adds a free-running WIDTH-bit sawtooth counter, reset 0, incremented by 1 every clk, wrapping at max.
  - It is selectable as src code 15 with sync asserted every clk.
- Undefined: code 15 behaves as any out-of-range select (data 0, no sync).

Decomposition:
- Shared package demod_dac_pkg holds:
  - CTRL/DECIM word offsets.
  - CTRL field bit positions.
  - TEST_TONE_SRC = 4'd15.
  - Saturating-shift function.
- Natural sub-module dac_output_channel: one per DAC, generated NUM_DAC times, containing stage 1/2, decimation counter and the per-channel registers. The top holds decode and the dout OR-tree.

Test Plan:
- Reset asserted mid-stream with channel 0 enabled → dacData = 0, dacSync = 0, CTRL reads 0, asynchronously without waiting for a clk edge.
- Ch0 CTRL = 0x80000002, srcSync[2] pulse with srcData[2] = 0x00123 → dacSync[0] pulses 2 cycles later, dacData[0] = 0x00123.
- Ch1 CTRL = 0x80000301 (shift 3), source 1 = 0x08000 → dacData[1] = 0x1FFFF (saturated); source 1 = 0x38000 (negative) → 0x20000.
- Ch2 DECIM = 3, source syncing every cycle → dacSync[2] on every 4th sync. Write DECIM = 3 again on a sync cycle → that sync is dropped and the count restarts.
- CTRL src = 9 with NUM_SRC = 8 → dacSync never asserts, dacData = 0. Writing only wr0 = 0x05 leaves the enable bit unchanged.
- With DAC_TEST_TONE_EN defined, src = 15, shift 0 → dacData increments by 1 every clk, dacSync continuously high; a build without the macro gives constant 0.
